// File: rtl/stream_compare_pkg.sv
// ---------------------------------------------------------------------------
// stream_compare_pkg
//   Shared types and helpers for the NCH-lane stream comparator.
//   lane_status_t carries one lane's live state from the lane to the top.
//   Its fields are sized for the widest supported configuration. Each lane
//   zero-extends its exact-width registers into it, and the top slices them
//   back down. The supported configuration is CNT_WIDTH <= MAX_CNT_WIDTH
//   and TDATA_WIDTH <= MAX_TDATA_WIDTH.
// ---------------------------------------------------------------------------
package stream_compare_pkg;

    localparam int unsigned MAX_CNT_WIDTH   = 64;
    localparam int unsigned MAX_TDATA_WIDTH = 512;

    typedef struct packed {
        logic [MAX_CNT_WIDTH-1:0]   word_cnt;   // live transfer count
        logic [MAX_CNT_WIDTH-1:0]   err_cnt;    // live mismatch count
        logic                       sticky;     // mismatch seen since clear
        logic                       halted;     // frozen by halt-on-error
        logic [MAX_CNT_WIDTH-1:0]   first_idx;  // word index of first mismatch
        logic [MAX_TDATA_WIDTH-1:0] first_xor;  // masked XOR of first mismatch
    } lane_status_t;

    // Saturating increment for a counter that is 'width' bits wide. The
    // counter is carried zero-extended in a MAX_CNT_WIDTH vector.
    function automatic logic [MAX_CNT_WIDTH-1:0] sat_inc(
        input logic [MAX_CNT_WIDTH-1:0] value,
        input int unsigned              width
    );
        logic [MAX_CNT_WIDTH-1:0] limit;
        limit = {MAX_CNT_WIDTH{1'b1}} >> (MAX_CNT_WIDTH - width);
        return (value >= limit) ? limit : value + MAX_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/stream_compare_lane.sv
// ---------------------------------------------------------------------------
// stream_compare_lane
//   One compare lane. It joins stream A (DUT) and stream B (expected) with a
//   common ready, compares the masked words, and keeps saturating word and
//   error counters. It also captures the first mismatch, can halt on error,
//   and produces a registered mismatch pulse.
// Ports
//   clk, aresetn        clock, synchronous active-low reset
//   a_tdata_i/tvalid_i  stream A word and valid
//   b_tdata_i/tvalid_i  stream B word and valid
//   tready_o            shared ready for A and B
//   cfg_clear_i         clear all lane state next cycle
//   cfg_trigger_en_i    enable mismatch pulses
//   cfg_halt_on_err_i   freeze lane on mismatch
//   cfg_mask_i          1 = bit compared
//   mismatch_o          registered one-cycle mismatch pulse
//   status_o            live counters, flags and first-error capture
// ---------------------------------------------------------------------------
module stream_compare_lane
    import stream_compare_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [TDATA_WIDTH-1:0] a_tdata_i,
    input  logic                   a_tvalid_i,
    input  logic [TDATA_WIDTH-1:0] b_tdata_i,
    input  logic                   b_tvalid_i,
    output logic                   tready_o,
    input  logic                   cfg_clear_i,
    input  logic                   cfg_trigger_en_i,
    input  logic                   cfg_halt_on_err_i,
    input  logic [TDATA_WIDTH-1:0] cfg_mask_i,
    output logic                   mismatch_o,
    output lane_status_t           status_o
);

    logic [CNT_WIDTH-1:0]   word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH-1:0]   first_idx_q, first_idx_d;
    logic [TDATA_WIDTH-1:0] first_xor_q, first_xor_d;
    logic                   sticky_q, sticky_d;
    logic                   halted_q, halted_d;
    logic                   mismatch_q, mismatch_d;
    logic [TDATA_WIDTH-1:0] diff;
    logic                   xfer;
    logic                   mis;

    // Ready depends on both valids. This keeps A and B in lockstep without
    // buffering. It is held low in the clear cycle and during reset, so no
    // word is accepted and then lost uncounted.
    assign tready_o = a_tvalid_i & b_tvalid_i & ~halted_q & ~cfg_clear_i & aresetn;
    assign xfer     = tready_o;
    assign diff     = (a_tdata_i ^ b_tdata_i) & cfg_mask_i;
    assign mis      = xfer & (|diff);

    always_comb begin
        // NOTE: every next-state variable gets a default first; a path that
        // leaves one unassigned would infer a latch.
        word_cnt_d  = word_cnt_q;
        err_cnt_d   = err_cnt_q;
        first_idx_d = first_idx_q;
        first_xor_d = first_xor_q;
        sticky_d    = sticky_q;
        halted_d    = halted_q;
        mismatch_d  = 1'b0;
        if (cfg_clear_i) begin
            word_cnt_d  = '0;
            err_cnt_d   = '0;
            first_idx_d = '0;
            first_xor_d = '0;
            sticky_d    = 1'b0;
            halted_d    = 1'b0;
        end else begin
            if (xfer) begin
                word_cnt_d = CNT_WIDTH'(sat_inc(MAX_CNT_WIDTH'(word_cnt_q), CNT_WIDTH));
            end
            if (mis) begin
                err_cnt_d = CNT_WIDTH'(sat_inc(MAX_CNT_WIDTH'(err_cnt_q), CNT_WIDTH));
            end
            // Only the first mismatch since clear is captured. The index is
            // the count before this word is added, so it is 0-based.
            if (mis && !sticky_q) begin
                first_idx_d = word_cnt_q;
                first_xor_d = diff;
                sticky_d    = 1'b1;
            end
            // Halt is sticky until cfg_clear. Dropping cfg_halt_on_err later
            // does not release the lane.
            halted_d   = halted_q | (mis & cfg_halt_on_err_i);
            mismatch_d = mis & cfg_trigger_en_i;
        end
    end

    // NOTE: the reset is synchronous, so the sensitivity list is the clock
    // only. State is updated with non-blocking assignments so that every
    // register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            word_cnt_q  <= '0;
            err_cnt_q   <= '0;
            first_idx_q <= '0;
            first_xor_q <= '0;
            sticky_q    <= 1'b0;
            halted_q    <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_idx_q <= first_idx_d;
            first_xor_q <= first_xor_d;
            sticky_q    <= sticky_d;
            halted_q    <= halted_d;
            mismatch_q  <= mismatch_d;
        end
    end

    assign mismatch_o = mismatch_q;

    always_comb begin
        status_o.word_cnt  = MAX_CNT_WIDTH'(word_cnt_q);
        status_o.err_cnt   = MAX_CNT_WIDTH'(err_cnt_q);
        status_o.sticky    = sticky_q;
        status_o.halted    = halted_q;
        status_o.first_idx = MAX_CNT_WIDTH'(first_idx_q);
        status_o.first_xor = MAX_TDATA_WIDTH'(first_xor_q);
    end

endmodule

// File: rtl/stream_compare_nch.sv
// ---------------------------------------------------------------------------
// stream_compare_nch
//   NCH-lane AXI-Stream comparator. Each lane compares stream A (DUT)
//   against stream B (expected) under a shared bit mask. The top fans out
//   the configuration, holds the snapshot counters and packs the lane
//   outputs.
// Ports
//   clk, aresetn                  clock, synchronous active-low reset
//   s_a_tdata/tvalid/tready       stream A, lane i at [i*TDATA_WIDTH +: TDATA_WIDTH]
//   s_b_tdata/tvalid/tready       stream B, same packing
//   cfg_clear                     pulse: clear live lane state
//   cfg_latch                     pulse: snapshot live counters (all lanes)
//   cfg_trigger_en                enable mismatch pulses
//   cfg_halt_on_err               freeze a lane on its first mismatch
//   cfg_mask                      1 = bit compared, shared by all lanes
//   mismatch / err_sticky / halted  per-lane flags
//   snap_word_count / snap_err_count  latched counters, CNT_WIDTH per lane
//   first_err_index / first_err_xor   first-mismatch capture per lane
// ---------------------------------------------------------------------------
module stream_compare_nch
    import stream_compare_pkg::*;
#(
    parameter int unsigned NCH         = 4,
    parameter int unsigned TDATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic [NCH*TDATA_WIDTH-1:0] s_a_tdata,
    input  logic [NCH-1:0]             s_a_tvalid,
    output logic [NCH-1:0]             s_a_tready,
    input  logic [NCH*TDATA_WIDTH-1:0] s_b_tdata,
    input  logic [NCH-1:0]             s_b_tvalid,
    output logic [NCH-1:0]             s_b_tready,
    input  logic                       cfg_clear,
    input  logic                       cfg_latch,
    input  logic                       cfg_trigger_en,
    input  logic                       cfg_halt_on_err,
    input  logic [TDATA_WIDTH-1:0]     cfg_mask,
    output logic [NCH-1:0]             mismatch,
    output logic [NCH-1:0]             err_sticky,
    output logic [NCH-1:0]             halted,
    output logic [NCH*CNT_WIDTH-1:0]   snap_word_count,
    output logic [NCH*CNT_WIDTH-1:0]   snap_err_count,
    output logic [NCH*CNT_WIDTH-1:0]   first_err_index,
    output logic [NCH*TDATA_WIDTH-1:0] first_err_xor
);

    lane_status_t [NCH-1:0]            lane_status;
    logic [NCH-1:0][CNT_WIDTH-1:0]     snap_word_q, snap_word_d;
    logic [NCH-1:0][CNT_WIDTH-1:0]     snap_err_q, snap_err_d;
    logic                              lane_status_unused;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        stream_compare_lane #(
            .TDATA_WIDTH (TDATA_WIDTH),
            .CNT_WIDTH   (CNT_WIDTH)
        ) u_lane (
            .clk               (clk),
            .aresetn           (aresetn),
            .a_tdata_i         (s_a_tdata[i*TDATA_WIDTH +: TDATA_WIDTH]),
            .a_tvalid_i        (s_a_tvalid[i]),
            .b_tdata_i         (s_b_tdata[i*TDATA_WIDTH +: TDATA_WIDTH]),
            .b_tvalid_i        (s_b_tvalid[i]),
            .tready_o          (s_a_tready[i]),
            .cfg_clear_i       (cfg_clear),
            .cfg_trigger_en_i  (cfg_trigger_en),
            .cfg_halt_on_err_i (cfg_halt_on_err),
            .cfg_mask_i        (cfg_mask),
            .mismatch_o        (mismatch[i]),
            .status_o          (lane_status[i])
        );

        assign err_sticky[i] = lane_status[i].sticky;
        assign halted[i]     = lane_status[i].halted;
        assign first_err_index[i*CNT_WIDTH +: CNT_WIDTH] =
            lane_status[i].first_idx[CNT_WIDTH-1:0];
        assign first_err_xor[i*TDATA_WIDTH +: TDATA_WIDTH] =
            lane_status[i].first_xor[TDATA_WIDTH-1:0];
        assign snap_word_count[i*CNT_WIDTH +: CNT_WIDTH] = snap_word_q[i];
        assign snap_err_count[i*CNT_WIDTH +: CNT_WIDTH]  = snap_err_q[i];
    end

    // A and B share one ready per lane.
    assign s_b_tready = s_a_tready;

    // The upper bits of the max-width status fields are zero by
    // construction. They are folded here so they are visibly consumed.
    assign lane_status_unused = ^lane_status;

    // The snapshot copies the registered live counters. A transfer in the
    // latch cycle is therefore excluded. If latch and clear arrive in the
    // same cycle, the snapshot still gets the pre-clear values.
    always_comb begin
        snap_word_d = snap_word_q;
        snap_err_d  = snap_err_q;
        if (cfg_latch) begin
            for (int i = 0; i < NCH; i++) begin
                snap_word_d[i] = lane_status[i].word_cnt[CNT_WIDTH-1:0];
                snap_err_d[i]  = lane_status[i].err_cnt[CNT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            snap_word_q <= '0;
            snap_err_q  <= '0;
        end else begin
            snap_word_q <= snap_word_d;
            snap_err_q  <= snap_err_d;
        end
    end

endmodule

// File: tb/tb_stream_compare_nch.sv
// ---------------------------------------------------------------------------
// tb_stream_compare_nch
//   Directed bench for stream_compare_nch. The main instance uses the
//   default sizes (4 lanes, 32-bit data, 32-bit counters). A second
//   single-lane instance has 4-bit counters and exercises saturation.
//   Inputs are driven 1 time unit after the rising edge. Outputs are
//   sampled before the next rising edge.
// ---------------------------------------------------------------------------
module tb_stream_compare_nch;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int CW  = 32;

    logic            clk = 1'b0;
    logic            aresetn;
    logic [NCH*DW-1:0] a_tdata, b_tdata;
    logic [NCH-1:0]  a_tvalid, b_tvalid, a_tready, b_tready;
    logic            cfg_clear, cfg_latch, cfg_trigger_en, cfg_halt_on_err;
    logic [DW-1:0]   cfg_mask;
    logic [NCH-1:0]  mismatch, err_sticky, halted;
    logic [NCH*CW-1:0] snap_word, snap_err, first_idx;
    logic [NCH*DW-1:0] first_xor;

    // Single-lane instance with 8-bit data and 4-bit counters.
    logic [7:0] sm_a_tdata, sm_b_tdata, sm_mask, sm_first_xor;
    logic [0:0] sm_a_tvalid, sm_b_tvalid, sm_a_tready, sm_b_tready;
    logic [0:0] sm_mismatch, sm_sticky, sm_halted;
    logic [3:0] sm_snap_word, sm_snap_err, sm_first_idx;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    stream_compare_nch #(.NCH(NCH), .TDATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .aresetn(aresetn),
        .s_a_tdata(a_tdata), .s_a_tvalid(a_tvalid), .s_a_tready(a_tready),
        .s_b_tdata(b_tdata), .s_b_tvalid(b_tvalid), .s_b_tready(b_tready),
        .cfg_clear(cfg_clear), .cfg_latch(cfg_latch),
        .cfg_trigger_en(cfg_trigger_en), .cfg_halt_on_err(cfg_halt_on_err),
        .cfg_mask(cfg_mask),
        .mismatch(mismatch), .err_sticky(err_sticky), .halted(halted),
        .snap_word_count(snap_word), .snap_err_count(snap_err),
        .first_err_index(first_idx), .first_err_xor(first_xor)
    );

    stream_compare_nch #(.NCH(1), .TDATA_WIDTH(8), .CNT_WIDTH(4)) dut_small (
        .clk(clk), .aresetn(aresetn),
        .s_a_tdata(sm_a_tdata), .s_a_tvalid(sm_a_tvalid), .s_a_tready(sm_a_tready),
        .s_b_tdata(sm_b_tdata), .s_b_tvalid(sm_b_tvalid), .s_b_tready(sm_b_tready),
        .cfg_clear(cfg_clear), .cfg_latch(cfg_latch),
        .cfg_trigger_en(cfg_trigger_en), .cfg_halt_on_err(cfg_halt_on_err),
        .cfg_mask(sm_mask),
        .mismatch(sm_mismatch), .err_sticky(sm_sticky), .halted(sm_halted),
        .snap_word_count(sm_snap_word), .snap_err_count(sm_snap_err),
        .first_err_index(sm_first_idx), .first_err_xor(sm_first_xor)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] sw(input int i);
        return 64'(snap_word[i*CW +: CW]);
    endfunction

    function automatic logic [63:0] se(input int i);
        return 64'(snap_err[i*CW +: CW]);
    endfunction

    function automatic logic [63:0] fi(input int i);
        return 64'(first_idx[i*CW +: CW]);
    endfunction

    function automatic logic [63:0] fx(input int i);
        return 64'(first_xor[i*DW +: DW]);
    endfunction

    task automatic drive(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic va, input logic vb);
        a_tdata[i*DW +: DW] = a;
        b_tdata[i*DW +: DW] = b;
        a_tvalid[i] = va;
        b_tvalid[i] = vb;
    endtask

    task automatic idle_all();
        a_tvalid    = '0;
        b_tvalid    = '0;
        sm_a_tvalid = '0;
        sm_b_tvalid = '0;
    endtask

    task automatic pulse_latch();
        cfg_latch = 1'b1;
        tick();
        cfg_latch = 1'b0;
    endtask

    task automatic pulse_clear();
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
    endtask

    // Lanes 1 and 2 each receive 8 words. Lane 1 differs at word 5
    // (0xFF vs 0x0F) and at word 7 (0x30 vs 0x10). Lane 2 always matches.
    task automatic run_vec(output logic [7:0] m1, output logic m2_any);
        logic [DW-1:0] a1, b1;
        m1 = '0;
        m2_any = 1'b0;
        for (int k = 0; k < 8; k++) begin
            a1 = (k == 5) ? 32'hFF : (k == 7) ? 32'h30 : DW'(k);
            b1 = (k == 5) ? 32'h0F : (k == 7) ? 32'h10 : DW'(k);
            drive(1, a1, b1, 1'b1, 1'b1);
            drive(2, DW'(k + 256), DW'(k + 256), 1'b1, 1'b1);
            tick();
            m1[k]  = mismatch[1];
            m2_any = m2_any | mismatch[2];
        end
        idle_all();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m1;
        logic       m2_any;
        logic       flag;
        logic [5:0] rdy;

        aresetn = 1'b0;
        a_tdata = '1; b_tdata = '0;
        a_tvalid = '1; b_tvalid = '1;
        sm_a_tdata = '0; sm_b_tdata = '0; sm_a_tvalid = '0; sm_b_tvalid = '0;
        sm_mask = 8'hFF;
        cfg_clear = 1'b0; cfg_latch = 1'b0;
        cfg_trigger_en = 1'b0; cfg_halt_on_err = 1'b0;
        cfg_mask = '1;

        // Reset: handshakes held low, everything zero.
        repeat (3) tick();
        check("rst_a_tready", 64'(a_tready), 64'h0);
        check("rst_b_tready", 64'(b_tready), 64'h0);
        check("rst_mismatch", 64'(mismatch), 64'h0);
        check("rst_sticky",   64'(err_sticky), 64'h0);
        check("rst_halted",   64'(halted), 64'h0);
        check("rst_snap_w0",  sw(0), 64'h0);
        check("rst_fxor1",    fx(1), 64'h0);
        idle_all();
        aresetn = 1'b1;
        tick();

        // Test 1: lane 0 sends 16 matching words.
        flag = 1'b1;
        m2_any = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            drive(0, DW'(k), DW'(k), 1'b1, 1'b1);
            #1;
            flag = flag & a_tready[0] & b_tready[0];
            tick();
            m2_any = m2_any | mismatch[0];
        end
        idle_all();
        check("t1_ready",    64'(flag), 64'h1);
        pulse_latch();
        check("t1_snap_w0",  sw(0), 64'd16);
        check("t1_snap_e0",  se(0), 64'd0);
        check("t1_mis_seen", 64'(m2_any), 64'h0);
        check("t1_sticky",   64'(err_sticky), 64'h0);

        // Test 2: lane 1 mismatches at word 5 (and 7) with the trigger on.
        pulse_clear();
        cfg_trigger_en = 1'b1;
        run_vec(m1, m2_any);
        check("t2_pulses",   64'(m1), 64'hA0);
        check("t2_lane2",    64'(m2_any), 64'h0);
        check("t2_fidx1",    fi(1), 64'd5);
        check("t2_fxor1",    fx(1), 64'hF0);
        check("t2_sticky",   64'(err_sticky), 64'h2);
        check("t2_halted",   64'(halted), 64'h0);
        pulse_latch();
        check("t2_snap_w1",  sw(1), 64'd8);
        check("t2_snap_e1",  se(1), 64'd2);
        check("t2_snap_w2",  sw(2), 64'd8);
        check("t2_snap_e2",  se(2), 64'd0);

        // Test 3: same vectors with mask 0x0F, where all differences are masked.
        pulse_clear();
        cfg_mask = 32'h0F;
        run_vec(m1, m2_any);
        check("t3_pulses",   64'(m1), 64'h0);
        check("t3_sticky",   64'(err_sticky), 64'h0);
        pulse_latch();
        check("t3_snap_e1",  se(1), 64'd0);
        check("t3_snap_w1",  sw(1), 64'd8);
        cfg_mask = '1;

        // Test 4: halt on the mismatch at word 3 of lane 3.
        pulse_clear();
        cfg_halt_on_err = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(3, DW'(k), (k == 3) ? DW'(k ^ 1) : DW'(k), 1'b1, 1'b1);
            #1;
            rdy[k] = a_tready[3];
            tick();
        end
        check("t4_ready_seq", 64'(rdy), 64'h0F);
        check("t4_halted",    64'(halted), 64'h8);
        cfg_halt_on_err = 1'b0;
        tick();
        check("t4_still_halt", 64'(halted[3]), 64'h1);
        check("t4_ready_low",  64'(a_tready[3]), 64'h0);
        idle_all();
        pulse_latch();
        check("t4_snap_w3",  sw(3), 64'd4);
        check("t4_snap_e3",  se(3), 64'd1);
        check("t4_fidx3",    fi(3), 64'd3);
        drive(3, 32'h9, 32'h9, 1'b1, 1'b1);
        pulse_clear();
        #1;
        check("t4_released", 64'(halted[3]), 64'h0);
        check("t4_ready_up", 64'(a_tready[3]), 64'h1);
        idle_all();
        pulse_latch();
        check("t4_clr_w3",   sw(3), 64'd0);
        check("t4_clr_e3",   se(3), 64'd0);
        check("t4_clr_stk",  64'(err_sticky), 64'h0);

        // Test 5: 4-bit counters saturate after 20 mismatching words.
        for (int k = 0; k < 20; k++) begin
            sm_a_tdata  = 8'(k);
            sm_b_tdata  = ~8'(k);
            sm_a_tvalid = 1'b1;
            sm_b_tvalid = 1'b1;
            tick();
        end
        idle_all();
        pulse_latch();
        check("t5_sat_word", 64'(sm_snap_word), 64'd15);
        check("t5_sat_err",  64'(sm_snap_err), 64'd15);
        check("t5_fidx",     64'(sm_first_idx), 64'd0);
        check("t5_fxor",     64'(sm_first_xor), 64'hFF);
        check("t5_sticky",   64'(sm_sticky), 64'h1);

        // Test 6: latch and clear in the same cycle, then B valid arrives late.
        pulse_clear();
        for (int k = 0; k < 7; k++) begin
            drive(0, DW'(k + 40), DW'(k + 40), 1'b1, 1'b1);
            tick();
        end
        drive(0, 32'h55, 32'h55, 1'b1, 1'b1);
        cfg_latch = 1'b1;
        cfg_clear = 1'b1;
        #1;
        check("t6_clr_ready", 64'(a_tready[0]), 64'h0);
        tick();
        cfg_latch = 1'b0;
        cfg_clear = 1'b0;
        idle_all();
        check("t6_snap_w0",  sw(0), 64'd7);
        pulse_latch();
        check("t6_live_w0",  sw(0), 64'd0);
        flag = 1'b0;
        drive(0, 32'hAA, 32'hAA, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            flag = flag | a_tready[0] | b_tready[0];
            tick();
        end
        check("t6_no_ready", 64'(flag), 64'h0);
        b_tvalid[0] = 1'b1;
        #1;
        check("t6_b_late",   64'(b_tready[0]), 64'h1);
        tick();
        idle_all();
        pulse_latch();
        check("t6_one_word", sw(0), 64'd1);

        // Reset mid-stream: ready drops at once and all state clears.
        drive(0, 32'h1, 32'h2, 1'b1, 1'b1);
        aresetn = 1'b0;
        #1;
        check("rst2_ready",  64'(a_tready[0]), 64'h0);
        tick();
        check("rst2_snap",   sw(0), 64'h0);
        check("rst2_sm",     64'(sm_snap_err), 64'h0);
        idle_all();
        aresetn = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
